// File: rtl/ltch_snap_buf_if.sv
// Capture/readout bus for the snapshot buffer: capture and pop strobes in,
// head word plus fill/overflow status out.
interface ltch_snap_buf_if #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    parameter int DROPW = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             en;
    logic [WIDTH-1:0] Din;
    logic             rd;
    logic             clr_ovf;
    logic [WIDTH-1:0] Q;
    logic             q_valid;
    logic [AW:0]      count;
    logic             full;
    logic             overflow;
    logic [DROPW-1:0] drop_cnt;

    modport master (
        output en, Din, rd, clr_ovf,
        input  Q, q_valid, count, full, overflow, drop_cnt
    );

    modport slave (
        input  en, Din, rd, clr_ovf,
        output Q, q_valid, count, full, overflow, drop_cnt
    );
endinterface

// File: rtl/ltch_snap_buf.sv
// DEPTH-entry snapshot buffer for TDC latch words, drained first-word-fall-through
// with sticky overflow and a saturating drop counter.
module ltch_snap_buf #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    parameter int DROPW = 8
) (
    input  logic               clk,
    input  logic               rst,
    ltch_snap_buf_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [DROPW-1:0] r_dropCnt;

    logic w_notEmpty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // A pop on the same edge frees a slot, so a capture into a full buffer is still accepted.
    assign w_notEmpty = (r_count != '0);
    assign w_pop      = bus.rd & w_notEmpty;
    assign w_push     = bus.en & ((r_count != CNT_FULL) | w_pop);
    assign w_drop     = bus.en & ~w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wrPtr] <= bus.Din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop on the same edge as clr_ovf wins, restarting the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (bus.clr_ovf) begin
                r_dropCnt <= DROPW'(1);
            end else if (r_dropCnt != '1) begin
                r_dropCnt <= r_dropCnt + 1'b1;
            end
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end
    end

    assign bus.Q        = r_mem[r_rdPtr];
    assign bus.q_valid  = w_notEmpty;
    assign bus.count    = r_count;
    assign bus.full     = (r_count == CNT_FULL);
    assign bus.overflow = r_overflow;
    assign bus.drop_cnt = r_dropCnt;
endmodule

// File: doc/ltch_snap_buf.md
Name: ltch_snap_buf

Overview:
- Parametrised successor to the fixed 33-bit enable latch: captures a WIDTH-bit word on every clock edge where en is high, into a DEPTH-entry snapshot buffer instead of a single register.
- Readout logic drains the buffer first-word-fall-through with a rd/q_valid handshake, so a burst of TDC latches between readout cycles is not lost.
- Reports fill level, a sticky overflow flag and a saturating drop counter.
- Sits between the TDC hit/time-word path and the readout sequencer.

Parameters:
- WIDTH, 33, data word width in bits (1..64).
- DEPTH, 4, number of buffer entries; power of two, 2..64.
- AW, log2(DEPTH), pointer width; derived, not overridden.
- DROPW, 8, width of the saturating drop counter.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  capture strobe; Din is written on the edge where en=1.
- Din  in  WIDTH  word to capture.
- rd  in  1  pop strobe from readout; consumes the head entry when q_valid=1.
- Q  out  WIDTH  head entry (oldest unread word).
- q_valid  out  1  buffer non-empty; Q is meaningful.
- count  out  AW+1  number of stored entries, 0..DEPTH.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; set when a capture is dropped.
- clr_ovf  in  1  clears overflow and drop_cnt.
- drop_cnt  out  DROPW  number of dropped captures, saturating at all-ones.

Behaviour:
- Reset (rst=1 at an edge) overrides all other inputs on that edge:
  - wr_ptr, rd_ptr and count go to 0; q_valid=0, full=0, overflow=0, drop_cnt=0.
  - All storage entries are cleared to 0, so Q=0.
  - A reset mid-burst discards all entries.
  - The first capture is accepted on the first edge with rst=0.
- Storage: DEPTH x WIDTH registers with clock-enabled writes. Q is driven from mem[rd_ptr], with no combinational path from Din.
- Capture:
  - The edge with en=1 and a free slot writes Din to mem[wr_ptr] and advances wr_ptr modulo DEPTH.
  - Latency into an empty buffer: one edge. The word is captured at edge k, and Q and q_valid=1 are valid after edge k.
- Pop:
  - The edge with rd=1 and q_valid=1 advances rd_ptr modulo DEPTH.
  - The next entry, if any, appears on Q after that edge.
  - rd with q_valid=0 is ignored, with no pointer or count change.
- Simultaneous en and rd with q_valid=1:
  - Both actions occur and count is unchanged.
  - This applies when full as well: the pop frees a slot in the same edge, so the capture is accepted and nothing is dropped.
  - When count==1, Q shows the new word after the edge.
- Full, with en=1 and no valid pop on that edge:
  - The word is dropped and storage is untouched.
  - overflow is set to 1 and drop_cnt increments, saturating at 2^DROPW-1.
- clr_ovf=1 at an edge:
  - overflow=0 and drop_cnt=0.
  - If a drop occurs on the same edge, the drop wins: overflow=1 and drop_cnt=1.
- count arithmetic: +1 on an accepted capture only, -1 on a valid pop only, unchanged for both or neither. count never exceeds DEPTH or goes below 0.
- Pointer wrap: plain modulo-DEPTH roll-over. Full and empty are distinguished by count, not by pointer equality.
- Legacy compatibility: with DEPTH=2, if en is asserted and rd is pulsed every cycle, Q follows Din one edge late. This matches the single-register behaviour.

Test Plan:
- Reset, then idle: rst high for 2 cycles, then low → Q=0, q_valid=0, count=0, full=0, overflow=0, drop_cnt=0.
- Single capture/pop: en=1 with Din=33'h1_2345_6789 for one edge → after the edge Q=33'h1_2345_6789, q_valid=1, count=1; rd=1 for one edge → q_valid=0, count=0.
- Fill, overflow and order (DEPTH=4): capture 1,2,3,4 then 5,6 with rd=0 → full=1, count=4, overflow=1, drop_cnt=2; pop four times → Q reads 1,2,3,4 in order, then q_valid=0.
- Simultaneous when full: full with contents 1..4, en=1 with Din=7 and rd=1 on the same edge → count stays 4, no drop, overflow unchanged; draining yields 2,3,4,7.
- Clear versus drop:
  - overflow=1, clr_ovf=1 alone → overflow=0, drop_cnt=0.
  - Repeat with clr_ovf=1 and a drop on the same edge → overflow=1, drop_cnt=1.
  - 300 consecutive drops with DROPW=8 → drop_cnt=255.
- Reset mid-operation: count=3, then rst=1 on the same edge as en=1 and rd=1 → count=0, q_valid=0, Q=0; the next edge with en=1 and Din=5 gives Q=5, count=1.
